esc_quad_drv: RTL and testbench

- Consumer end of the flight-control motor-speed interface.
- Accepts the four 11-bit unsigned motor speeds (front/back/left/right) plus a write strobe, and drives four ESC PWM lines.
- Includes a power-up arming sequence and a command watchdog that fails safe to minimum throttle.
- Sits between the flight-control math and the motor pads; pulse widths change only on PWM period boundaries.

---
 rtl/esc_pkg.sv | 18 +
 rtl/esc_pwm_ch.sv | 54 +++++
 rtl/esc_quad_drv.sv | 183 ++++++++++++++++++
 tb/tb_esc_quad_drv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// esc_pkg: shared types and channel indices for the quad ESC driver.
package esc_pkg;

    typedef logic [10:0] spd_t;

    typedef enum logic [1:0] {
        ARMING,
        RUN,
        FAILSAFE
    } esc_state_t;

    localparam int NUM_CH = 4;
    localparam int FRNT   = 0;
    localparam int BCK    = 1;
    localparam int LFT    = 2;
    localparam int RGHT   = 3;

endpackage

// File: rtl/esc_pwm_ch.sv
// esc_pwm_ch: one ESC channel -- active speed register, pulse width
// and registered period comparator.
module esc_pwm_ch
    import esc_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int BASE_CLKS = 50000,
    parameter int SCALE     = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] cnt,
    input  logic                boundary,
    input  logic                load,
    input  logic                zero,
    input  logic [10:0]         new_spd,
    output logic                pwm
);

    spd_t                active_q;
    spd_t                active_d;
    logic                pwm_q;
    logic                pwm_d;
    logic [PERIOD_W-1:0] pulse;

    // Active speed only moves at a period boundary, so a pulse in
    // flight always finishes with the width it started with.
    always_comb begin
        active_d = active_q;
        if (boundary) begin
            if (zero) begin
                active_d = '0;
            end else if (load) begin
                active_d = new_spd;
            end
        end
        pulse = PERIOD_W'(BASE_CLKS)
              + PERIOD_W'(SCALE) * PERIOD_W'(active_q);
        pwm_d = (cnt < pulse);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/esc_quad_drv.sv
// esc_quad_drv: four-channel ESC PWM driver with power-up arming
// and a command watchdog that falls back to minimum throttle.
module esc_quad_drv
    import esc_pkg::*;
#(
    parameter int PERIOD_W     = 20,
    parameter int BASE_CLKS    = 50000,
    parameter int SCALE        = 24,
    parameter int ARM_PERIODS  = 8,
    parameter int WDOG_PERIODS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        pwm_frnt,
    output logic        pwm_bck,
    output logic        pwm_lft,
    output logic        pwm_rght,
    output logic        armed,
    output logic        wdog_trip
);

    localparam int ARM_W  = $clog2(ARM_PERIODS + 1);
    localparam int WDOG_W = $clog2(WDOG_PERIODS + 1);

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [ARM_W-1:0]    ARM_LAST  = ARM_W'(ARM_PERIODS - 1);
    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WDOG_PERIODS - 1);

    if (BASE_CLKS + SCALE * 2047 >= (1 << PERIOD_W)) begin : g_bad_cfg
        $error("esc_quad_drv: maximum pulse does not fit in the period");
    end

    esc_state_t             state_q;
    esc_state_t             state_d;
    logic [PERIOD_W-1:0]    cnt_q;
    logic [PERIOD_W-1:0]    cnt_d;
    spd_t [NUM_CH-1:0]      shadow_q;
    spd_t [NUM_CH-1:0]      shadow_d;
    logic                   fresh_q;
    logic                   fresh_d;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic [ARM_W-1:0]       arm_cnt_d;
    logic [WDOG_W-1:0]      wdog_cnt_q;
    logic [WDOG_W-1:0]      wdog_cnt_d;
    logic                   armed_q;
    logic                   armed_d;
    logic                   wdog_trip_q;
    logic                   wdog_trip_d;

    logic                   boundary;
    logic                   cmd;
    logic                   load;
    logic                   zero;
    spd_t [NUM_CH-1:0]      port_spd;
    spd_t [NUM_CH-1:0]      new_spd;
    logic [NUM_CH-1:0]      pwm_v;

    always_comb begin
        port_spd[FRNT] = frnt_spd;
        port_spd[BCK]  = bck_spd;
        port_spd[LFT]  = lft_spd;
        port_spd[RGHT] = rght_spd;
    end

    // A write landing on the boundary cycle bypasses the shadow so
    // it takes effect in the very next period.
    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cmd      = fresh_q | wrt;
        new_spd  = wrt ? port_spd : shadow_q;
        cnt_d    = cnt_q + 1'b1;
        shadow_d = wrt ? port_spd : shadow_q;

        fresh_d = fresh_q;
        if (wrt) begin
            fresh_d = 1'b1;
        end else if (boundary) begin
            fresh_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        wdog_cnt_d  = wdog_cnt_q;
        armed_d     = armed_q;
        wdog_trip_d = wdog_trip_q;
        load        = 1'b0;
        zero        = 1'b0;

        if (boundary) begin
            unique case (state_q)
                ARMING: begin
                    zero      = 1'b1;
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    if (arm_cnt_q == ARM_LAST) begin
                        state_d    = RUN;
                        armed_d    = 1'b1;
                        wdog_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (cmd) begin
                        load       = 1'b1;
                        wdog_cnt_d = '0;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + 1'b1;
                        if (wdog_cnt_q == WDOG_LAST) begin
                            state_d     = FAILSAFE;
                            zero        = 1'b1;
                            wdog_trip_d = 1'b1;
                        end
                    end
                end
                FAILSAFE: begin
                    if (cmd) begin
                        load        = 1'b1;
                        wdog_trip_d = 1'b0;
                        wdog_cnt_d  = '0;
                        state_d     = RUN;
                    end else begin
                        zero = 1'b1;
                    end
                end
                default: begin
                    state_d = ARMING;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARMING;
            cnt_q       <= '0;
            shadow_q    <= '0;
            fresh_q     <= 1'b0;
            arm_cnt_q   <= '0;
            wdog_cnt_q  <= '0;
            armed_q     <= 1'b0;
            wdog_trip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            fresh_q     <= fresh_d;
            arm_cnt_q   <= arm_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            armed_q     <= armed_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pwm_ch #(
            .PERIOD_W  (PERIOD_W),
            .BASE_CLKS (BASE_CLKS),
            .SCALE     (SCALE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt_q),
            .boundary (boundary),
            .load     (load),
            .zero     (zero),
            .new_spd  (new_spd[i]),
            .pwm      (pwm_v[i])
        );
    end

    assign pwm_frnt  = pwm_v[FRNT];
    assign pwm_bck   = pwm_v[BCK];
    assign pwm_lft   = pwm_v[LFT];
    assign pwm_rght  = pwm_v[RGHT];
    assign armed     = armed_q;
    assign wdog_trip = wdog_trip_q;

endmodule

// File: tb/tb_esc_quad_drv.sv
// tb_esc_quad_drv: period-by-period stimulus with a per-channel
// pulse-width scoreboard for esc_quad_drv.
module tb_esc_quad_drv;
    import esc_pkg::*;

    localparam int PW   = 12;
    localparam int P    = 1 << PW;
    localparam int BASE = 1000;
    localparam int SC   = 1;
    localparam int ARM  = 3;
    localparam int WDOG = 4;

    typedef logic [3:0][10:0] spd4_t;
    typedef logic [3:0][15:0] wid4_t;

    typedef struct packed {
        spd4_t       s;
        logic [15:0] at;
        wid4_t       w;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  wrt = 1'b0;
    spd_t  frnt_spd, bck_spd, lft_spd, rght_spd;
    logic  pwm_frnt, pwm_bck, pwm_lft, pwm_rght;
    logic  armed, wdog_trip;
    logic [3:0] pwm_v;

    int npass = 0;
    int ntot  = 0;
    int exp_q [4][$];
    int hi [4];
    logic [3:0] prev;
    vec_t vecs [3];

    always #5 clk = ~clk;

    esc_quad_drv #(
        .PERIOD_W     (PW),
        .BASE_CLKS    (BASE),
        .SCALE        (SC),
        .ARM_PERIODS  (ARM),
        .WDOG_PERIODS (WDOG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt       (wrt),
        .frnt_spd  (frnt_spd),
        .bck_spd   (bck_spd),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .pwm_frnt  (pwm_frnt),
        .pwm_bck   (pwm_bck),
        .pwm_lft   (pwm_lft),
        .pwm_rght  (pwm_rght),
        .armed     (armed),
        .wdog_trip (wdog_trip)
    );

    assign pwm_v = {pwm_rght, pwm_lft, pwm_bck, pwm_frnt};

    task automatic chk(input string name, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic spd4_t mks(input int f, input int b,
                                  input int l, input int r);
        return {11'(r), 11'(l), 11'(b), 11'(f)};
    endfunction

    function automatic wid4_t mkw(input int f, input int b,
                                  input int l, input int r);
        return {16'(r), 16'(l), 16'(b), 16'(f)};
    endfunction

    function automatic vec_t mkv(input spd4_t s, input int at,
                                 input wid4_t w);
        vec_t v;
        v.s  = s;
        v.at = 16'(at);
        v.w  = w;
        return v;
    endfunction

    task automatic set_spd(input spd4_t s);
        frnt_spd = s[FRNT];
        bck_spd  = s[BCK];
        lft_spd  = s[LFT];
        rght_spd = s[RGHT];
    endtask

    function automatic spd4_t rnd_spd();
        return mks($urandom_range(0, 2047), $urandom_range(0, 2047),
                   $urandom_range(0, 2047), $urandom_range(0, 2047));
    endfunction

    // Pulse width monitor: a falling edge retires the oldest width
    // expected on that channel.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) hi[c] = 0;
            prev = '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (pwm_v[c]) begin
                    hi[c]++;
                end else if (prev[c]) begin
                    if (exp_q[c].size() == 0) begin
                        ntot++;
                        $display("FAIL width_ch%0d: got %0d, expected none",
                                 c, hi[c]);
                    end else begin
                        chk($sformatf("width_ch%0d", c), hi[c],
                            exp_q[c].pop_front());
                    end
                    hi[c] = 0;
                end
            end
            prev = pwm_v;
        end
    end

    // Runs one period starting at cnt==0; wrt is pulsed at cnt==at.
    task automatic start_period(input wid4_t w, input logic ea,
                                input logic et);
        chk("armed_start", int'(armed), int'(ea));
        chk("trip_start", int'(wdog_trip), int'(et));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("pending_ch%0d", c), exp_q[c].size(), 0);
            exp_q[c].push_back(int'(w[c]));
        end
    endtask

    task automatic run_period(input wid4_t w, input logic ea,
                              input logic et, input int at,
                              input spd4_t s);
        start_period(w, ea, et);
        for (int i = 0; i < P; i++) begin
            if (i == at) begin
                wrt = 1'b1;
                set_spd(s);
            end else begin
                wrt = 1'b0;
                set_spd(rnd_spd());
            end
            if (i == P - 1) begin
                chk("armed_end", int'(armed), int'(ea));
                chk("trip_end", int'(wdog_trip), int'(et));
            end
            @(negedge clk);
        end
        wrt = 1'b0;
    endtask

    initial begin
        wid4_t w_min, w_byp, w_rec;
        spd4_t s_byp, s_zero;
        w_min  = mkw(1000, 1000, 1000, 1000);
        s_byp  = mks(50, 1, 2, 3);
        w_byp  = mkw(1050, 1001, 1002, 1003);
        w_rec  = mkw(1300, 1000, 1000, 1000);
        s_zero = mks(0, 0, 0, 0);

        vecs[0] = mkv(mks(100, 200, 0, 2047), 3000,
                      mkw(1100, 1200, 1000, 3047));
        vecs[1] = mkv(mks(2047, 0, 1024, 1), 10,
                      mkw(3047, 1000, 2024, 1001));
        vecs[2] = mkv(mks(5, 1500, 700, 2000), 4000,
                      mkw(1005, 2500, 1700, 3000));

        set_spd(s_zero);
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_v), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_trip", int'(wdog_trip), 0);
        rst_n = 1'b1;

        // Arming; a command in the last arming period must be dropped.
        run_period(w_min, 1'b0, 1'b0, -1, s_zero);
        run_period(w_min, 1'b0, 1'b0, -1, s_zero);
        run_period(w_min, 1'b0, 1'b0, 100, mks(500, 500, 500, 500));
        run_period(w_min, 1'b1, 1'b0, -1, s_zero);

        run_period(w_min, 1'b1, 1'b0, int'(vecs[0].at), vecs[0].s);
        for (int k = 1; k < 3; k++) begin
            run_period(vecs[k-1].w, 1'b1, 1'b0, int'(vecs[k].at),
                       vecs[k].s);
        end

        // Write on the boundary cycle itself.
        run_period(vecs[2].w, 1'b1, 1'b0, P - 1, s_byp);

        // Boundary write leaves fresh set, so the first idle boundary
        // still counts as a command; trip on the fourth after it.
        for (int k = 0; k < 5; k++) begin
            run_period(w_byp, 1'b1, 1'b0, -1, s_zero);
        end
        run_period(w_min, 1'b1, 1'b1, 200, mks(300, 0, 0, 0));
        run_period(w_rec, 1'b1, 1'b0, -1, s_zero);

        // Reset in the middle of a pulse.
        start_period(w_rec, 1'b1, 1'b0);
        for (int i = 0; i < 500; i++) begin
            set_spd(rnd_spd());
            @(negedge clk);
        end
        chk("pre_rst_pwm", int'(pwm_v), 15);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(pwm_v), 0);
        chk("mid_rst_armed", int'(armed), 0);
        chk("mid_rst_trip", int'(wdog_trip), 0);
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < ARM; k++) begin
            run_period(w_min, 1'b0, 1'b0, -1, s_zero);
        end
        chk("rearmed", int'(armed), 1);
        chk("rearm_trip", int'(wdog_trip), 0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("final_pending_ch%0d", c), exp_q[c].size(), 0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
